// File: rtl/gain_cal_pkg.sv
// rtl/gain_cal_pkg.sv - shared types and constants for the gain/offset estimator
//
// Purpose : FSM state enum, Q2.14 unity, 16-bit signed limits, overflow lane
//           bit indices and a saturating 18->16 bit helper.
// Ports   : none (package).
package gain_cal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } est_state_t;

  localparam logic [15:0] Q2_14_ONE = 16'h4000;

  localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] S16_MIN = 16'sh8000;

  // Lane positions inside overflow_i.
  localparam int OVF_X0  = 0;
  localparam int OVF_X0Z = 1;
  localparam int OVF_X1  = 2;
  localparam int OVF_X1Z = 3;

  // Clamp an 18-bit signed intermediate into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return S16_MAX;
    end else if (v < -18'sd32768) begin
      return S16_MIN;
    end else begin
      return $signed(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/gain_offset_estimator_if.sv
// rtl/gain_offset_estimator_if.sv - sample/control/result bundle of the estimator
//
// Purpose : groups the two-channel sample streams, overflow flags, window
//           handshake and the control-word results into one bundle.
// Signals : x0_i/x0z_i/x1_i/x1z_i  signed sample pairs per clock
//           overflow_i             per-lane overflow flags
//           start_i/busy_o/done_o  window handshake
//           offset_control_*_o, gain_control_*_o, ovf_count_*_o  results
// Modports: master (sample source / controller), slave (estimator).
interface gain_offset_estimator_if;

  logic signed [15:0] x0_i;
  logic signed [15:0] x0z_i;
  logic signed [15:0] x1_i;
  logic signed [15:0] x1z_i;
  logic        [3:0]  overflow_i;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic signed [15:0] offset_control_1_o;
  logic signed [15:0] offset_control_2_o;
  logic signed [15:0] gain_control_1_o;
  logic signed [15:0] gain_control_2_o;
  logic        [15:0] ovf_count_1_o;
  logic        [15:0] ovf_count_2_o;

  modport master (
    output x0_i, x0z_i, x1_i, x1z_i, overflow_i, start_i,
    input  busy_o, done_o,
    input  offset_control_1_o, offset_control_2_o,
    input  gain_control_1_o, gain_control_2_o,
    input  ovf_count_1_o, ovf_count_2_o
  );

  modport slave (
    input  x0_i, x0z_i, x1_i, x1z_i, overflow_i, start_i,
    output busy_o, done_o,
    output offset_control_1_o, offset_control_2_o,
    output gain_control_1_o, gain_control_2_o,
    output ovf_count_1_o, ovf_count_2_o
  );

endinterface

// File: rtl/gain_offset_estimator_chan.sv
// rtl/gain_offset_estimator_chan.sv - per-channel accumulator, overflow count and word update
//
// Purpose : module gain_offset_chan. Sums the sample pair every accumulate
//           cycle, counts overflow clocks (saturating), and on update moves
//           the offset word against the window mean and optionally backs off
//           the gain word.
// Ports   : clk, rst_n_i           clock, synchronous active-low reset
//           i_clear                start of window: zero accumulator/counter
//           i_accum                accumulate this cycle's samples
//           i_update               commit new offset/gain/count
//           i_a, i_b               signed sample pair
//           i_ovf                  overflow flags of this channel's two lanes
//           o_offset, o_gain       control words
//           o_ovf_count            overflow clock count of the last window
// Macro   : GAIN_OFFSET_EST_GAIN_ADAPT_EN enables gain back-off; otherwise
//           o_gain is the constant GAIN_INIT.
module gain_offset_chan
  import gain_cal_pkg::*;
#(
  parameter int          LOG2_WINDOW = 10,
  parameter logic [15:0] GAIN_INIT   = Q2_14_ONE,
  parameter logic [15:0] GAIN_STEP   = 16'd64
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               i_clear,
  input  logic               i_accum,
  input  logic               i_update,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic        [1:0]  i_ovf,
  output logic signed [15:0] o_offset,
  output logic signed [15:0] o_gain,
  output logic        [15:0] o_ovf_count
);

  localparam int AW = 17 + LOG2_WINDOW;

  logic signed [AW-1:0] r_acc;
  logic        [15:0]   r_cnt;
  logic signed [15:0]   r_offset;
  logic        [15:0]   r_ovf_count;

  logic signed [AW-1:0] w_a_ext;
  logic signed [AW-1:0] w_b_ext;
  logic signed [15:0]   w_mean;
  logic signed [17:0]   w_diff;
  logic signed [15:0]   w_offset_new;

  assign w_a_ext = {{(AW-16){i_a[15]}}, i_a};
  assign w_b_ext = {{(AW-16){i_b[15]}}, i_b};

  // Arithmetic shift by LOG2_WINDOW+1 (floor division) is just the upper bits
  // of the two's-complement accumulator; the mean always fits 16 bits.
  assign w_mean       = $signed(r_acc[LOG2_WINDOW+16:LOG2_WINDOW+1]);
  assign w_diff       = {{2{r_offset[15]}}, r_offset} - {{2{w_mean[15]}}, w_mean};
  assign w_offset_new = sat16(w_diff);

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_offset    <= '0;
      r_ovf_count <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_accum) begin
        r_acc <= r_acc + w_a_ext + w_b_ext;
        if ((|i_ovf) && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      if (i_update) begin
        r_offset    <= w_offset_new;
        r_ovf_count <= r_cnt;
      end
    end
  end

  assign o_offset    = r_offset;
  assign o_ovf_count = r_ovf_count;

`ifdef GAIN_OFFSET_EST_GAIN_ADAPT_EN
  logic signed [15:0] r_gain;
  logic signed [16:0] w_gain_dec;

  // One extra bit so that a step larger than the current gain shows up as a
  // negative result, which clamps to zero.
  assign w_gain_dec = {r_gain[15], r_gain} - $signed({1'b0, GAIN_STEP});

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_gain <= GAIN_INIT;
    end else if (i_update && (r_cnt != 16'd0)) begin
      r_gain <= w_gain_dec[16] ? 16'sd0 : $signed(w_gain_dec[15:0]);
    end
  end

  assign o_gain = r_gain;
`else
  assign o_gain = GAIN_INIT;
`endif

endmodule

// File: rtl/gain_offset_estimator.sv
// rtl/gain_offset_estimator.sv - windowed closed-loop gain/offset calibration
//
// Purpose : runs one estimation window per accepted start. Accumulates both
//           channels for 2^LOG2_WINDOW clocks, then updates the offset (and
//           optionally gain) control words; done_o pulses when the new words
//           are visible.
// Ports   : clk       sample clock
//           rst_n_i   synchronous active-low reset
//           bus       gain_offset_estimator_if.slave (samples, overflow flags,
//                     start/busy/done, control words, overflow counts)
// Macro   : GAIN_OFFSET_EST_GAIN_ADAPT_EN enables the gain back-off path.
module gain_offset_estimator
  import gain_cal_pkg::*;
#(
  parameter int          LOG2_WINDOW = 10,
  parameter logic [15:0] GAIN_INIT   = Q2_14_ONE,
  parameter logic [15:0] GAIN_STEP   = 16'd64
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  gain_offset_estimator_if.slave  bus
);

  est_state_t             r_state;
  est_state_t             w_state_next;
  logic [LOG2_WINDOW-1:0] r_win;
  logic                   r_busy;
  logic                   r_done;

  logic w_clear;
  logic w_accum;
  logic w_update;
  logic w_win_last;

  assign w_win_last = (r_win == {LOG2_WINDOW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Flags follow the next state so they line up with it as registers.
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accum      = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_next = ST_ACCUM;
          w_clear      = 1'b1;
        end
      end
      ST_ACCUM: begin
        w_accum = 1'b1;
        if (w_win_last) begin
          w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_update     = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_win <= '0;
    end else if (w_clear) begin
      r_win <= '0;
    end else if (w_accum) begin
      r_win <= r_win + 1'b1;
    end
  end

  gain_offset_chan #(
    .LOG2_WINDOW (LOG2_WINDOW),
    .GAIN_INIT   (GAIN_INIT),
    .GAIN_STEP   (GAIN_STEP)
  ) u_chan1 (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .i_clear     (w_clear),
    .i_accum     (w_accum),
    .i_update    (w_update),
    .i_a         (bus.x0_i),
    .i_b         (bus.x0z_i),
    .i_ovf       ({bus.overflow_i[OVF_X0Z], bus.overflow_i[OVF_X0]}),
    .o_offset    (bus.offset_control_1_o),
    .o_gain      (bus.gain_control_1_o),
    .o_ovf_count (bus.ovf_count_1_o)
  );

  gain_offset_chan #(
    .LOG2_WINDOW (LOG2_WINDOW),
    .GAIN_INIT   (GAIN_INIT),
    .GAIN_STEP   (GAIN_STEP)
  ) u_chan2 (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .i_clear     (w_clear),
    .i_accum     (w_accum),
    .i_update    (w_update),
    .i_a         (bus.x1_i),
    .i_b         (bus.x1z_i),
    .i_ovf       ({bus.overflow_i[OVF_X1Z], bus.overflow_i[OVF_X1]}),
    .o_offset    (bus.offset_control_2_o),
    .o_gain      (bus.gain_control_2_o),
    .o_ovf_count (bus.ovf_count_2_o)
  );

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;

endmodule
